color_freq_emulator: RTL and testbench

//  Light-to-frequency sensor emulator: the sensor end of the colour-sensor interface.

---
 rtl/color_freq_emulator.sv | 192 +++++++++++++++++++
 tb/tb_color_freq_emulator.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_freq_emulator.sv
// color_freq_emulator: sensor end of the colour-sensor link, emitting a square wave whose
// half-period is the selected channel's value scaled by the scale select. `COLOR_EMU_JITTER_EN adds LFSR jitter.
module color_freq_emulator #(
  parameter int          HP_W       = 16,
  parameter int          SETTLE_CYC = 100,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      scale,
  input  logic [1:0]      filter,
  input  logic [HP_W-1:0] red_hp,
  input  logic [HP_W-1:0] blue_hp,
  input  logic [HP_W-1:0] green_hp,
  input  logic [HP_W-1:0] clear_hp,
  output logic            sensorFreq,
  output logic            settling,
  output logic [31:0]     edge_cnt
);

  localparam int HPE_W = HP_W + 6;
  localparam int SC_W  = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    SETTLE_S = 2'd1,
    RUN_S    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       scale_q, scale_prev_q;
  logic [1:0]       filter_q, filter_prev_q;
  logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [HPE_W-1:0] hp_cnt_q, hp_cnt_d;
  logic [HPE_W-1:0] hpe_q, hpe_d;
  logic             freq_q, freq_d;
  logic             settling_q;
  logic [31:0]      edge_cnt_q, edge_cnt_d;

  logic [HP_W-1:0]  hp_sel_s;
  logic [5:0]       mult_s;
  logic [HPE_W-1:0] hpe_s;
  logic [HPE_W-1:0] hpe_lat_s;
  logic             zero_s;
  logic             change_s;
  logic             toggle_s;

  // Select pipeline: a change is the registered select differing from its previous registered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q       <= 2'b00;
      scale_prev_q  <= 2'b00;
      filter_q      <= 2'b00;
      filter_prev_q <= 2'b00;
    end else begin
      scale_prev_q  <= scale_q;
      scale_q       <= scale;
      filter_prev_q <= filter_q;
      filter_q      <= filter;
    end
  end

  // Channel and multiplier selection from the registered selects.
  always_comb begin
    hp_sel_s = clear_hp;
    mult_s   = 6'd0;
    case (filter_q)
      2'b00:   hp_sel_s = red_hp;
      2'b01:   hp_sel_s = blue_hp;
      2'b11:   hp_sel_s = green_hp;
      default: hp_sel_s = clear_hp;
    endcase
    case (scale_q)
      2'b11:   mult_s = 6'd1;
      2'b10:   mult_s = 6'd5;
      2'b01:   mult_s = 6'd50;
      default: mult_s = 6'd0;
    endcase
  end

  assign hpe_s    = HPE_W'(hp_sel_s) * HPE_W'(mult_s);
  assign zero_s   = (scale_q == 2'b00) || (hp_sel_s == {HP_W{1'b0}});
  assign change_s = (scale_q != scale_prev_q) || (filter_q != filter_prev_q);
  assign toggle_s = (state_q == RUN_S) && (hp_cnt_q == (hpe_q - HPE_W'(1)));

`ifdef COLOR_EMU_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [HPE_W-1:0] jitter_adj(input logic [HPE_W-1:0] h, input logic [15:0] l);
    logic [HPE_W-1:0] r;
    r = h;
    if (l[0] && !l[1]) begin
      r = h + HPE_W'(1);
    end else if (l[0] && l[1] && (h != HPE_W'(1))) begin
      r = h - HPE_W'(1);
    end else begin
      r = h;
    end
    return r;
  endfunction

  assign hpe_lat_s = jitter_adj(hpe_s, lfsr_q);
  assign lfsr_d    = (toggle_s && !zero_s) ? lfsr_next(lfsr_q) : lfsr_q;

  // Jitter LFSR steps once per emitted toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_seed_s;
  assign unused_seed_s = ^LFSR_SEED;
  assign hpe_lat_s     = hpe_s;
`endif

  // Next-state logic; power-down/zero beats a select change, which beats the natural transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    hp_cnt_d     = hp_cnt_q;
    hpe_d        = hpe_q;
    freq_d       = freq_q;
    edge_cnt_d   = edge_cnt_q;
    case (state_q)
      IDLE_S: begin
        freq_d       = 1'b0;
        state_d      = SETTLE_S;
        settle_cnt_d = {SC_W{1'b0}};
      end
      SETTLE_S: begin
        if (settle_cnt_q == SC_W'(SETTLE_CYC - 1)) begin
          state_d  = RUN_S;
          hp_cnt_d = {HPE_W{1'b0}};
          hpe_d    = hpe_lat_s;
        end else begin
          settle_cnt_d = settle_cnt_q + SC_W'(1);
        end
      end
      RUN_S: begin
        if (toggle_s) begin
          freq_d     = ~freq_q;
          hp_cnt_d   = {HPE_W{1'b0}};
          hpe_d      = hpe_lat_s;
          edge_cnt_d = freq_q ? edge_cnt_q : (edge_cnt_q + 32'd1);
        end else begin
          hp_cnt_d = hp_cnt_q + HPE_W'(1);
        end
      end
      default: begin
        state_d = IDLE_S;
        freq_d  = 1'b0;
      end
    endcase
    state_d      = zero_s ? IDLE_S : (change_s ? SETTLE_S : state_d);
    settle_cnt_d = (!zero_s && change_s) ? {SC_W{1'b0}} : settle_cnt_d;
    freq_d       = zero_s ? 1'b0 : freq_d;
    edge_cnt_d   = zero_s ? edge_cnt_q : edge_cnt_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE_S;
      settle_cnt_q <= {SC_W{1'b0}};
      hp_cnt_q     <= {HPE_W{1'b0}};
      hpe_q        <= {HPE_W{1'b0}};
      freq_q       <= 1'b0;
      settling_q   <= 1'b0;
      edge_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      hp_cnt_q     <= hp_cnt_d;
      hpe_q        <= hpe_d;
      freq_q       <= freq_d;
      settling_q   <= (state_d == SETTLE_S);
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  assign sensorFreq = freq_q;
  assign settling   = settling_q;
  assign edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_color_freq_emulator.sv
// Bench for color_freq_emulator: directed table of configurations, hand-written corner sequences and
// randomized traffic, all checked against a countdown-style behavioural model.
module tb_color_freq_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  scale, filter;
  logic [15:0] red_hp, blue_hp, green_hp, clear_hp;
  logic        sensorFreq, settling;
  logic [31:0] edge_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode 0=idle, 1=settle, 2=run; timers count down to the next event.
  int          m_mode, m_left, m_remain;
  logic        m_freq;
  logic [31:0] m_edges;
  logic [1:0]  m_sc_r, m_sc_p, m_fl_r, m_fl_p;
  logic [15:0] m_lfsr;

  typedef struct {
    logic [1:0]  sc;
    logic [1:0]  fl;
    logic [15:0] r, b, g, c;
    int          hp;
  } vec_t;
  vec_t tbl [6];

  color_freq_emulator dut (
    .clk(clk), .rst_n(rst_n), .scale(scale), .filter(filter),
    .red_hp(red_hp), .blue_hp(blue_hp), .green_hp(green_hp), .clear_hp(clear_hp),
    .sensorFreq(sensorFreq), .settling(settling), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hp_of(input logic [1:0] f);
    case (f)
      2'b00:   return int'(red_hp);
      2'b01:   return int'(blue_hp);
      2'b11:   return int'(green_hp);
      default: return int'(clear_hp);
    endcase
  endfunction

  function automatic int mult_of(input logic [1:0] s);
    case (s)
      2'b11:   return 1;
      2'b10:   return 5;
      2'b01:   return 50;
      default: return 0;
    endcase
  endfunction

`ifdef COLOR_EMU_JITTER_EN
  function automatic int jit(input int h);
    if (m_lfsr[0] && !m_lfsr[1]) return h + 1;
    if (m_lfsr[0] && m_lfsr[1] && h != 1) return h - 1;
    return h;
  endfunction
  task automatic adv_lfsr();
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask
`else
  function automatic int jit(input int h);
    return h;
  endfunction
  task automatic adv_lfsr();
  endtask
`endif

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_remain = 0; m_freq = 1'b0; m_edges = 32'd0;
    m_sc_r = 2'b00; m_sc_p = 2'b00; m_fl_r = 2'b00; m_fl_p = 2'b00;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_tick();
    int hp, hpe;
    bit dead, chg;
    hp   = hp_of(m_fl_r);
    hpe  = hp * mult_of(m_sc_r);
    dead = (m_sc_r == 2'b00) || (hp == 0);
    chg  = (m_sc_r != m_sc_p) || (m_fl_r != m_fl_p);
    if (dead) begin
      m_mode = 0;
      m_freq = 1'b0;
    end else begin
      if (m_mode == 2) begin
        m_remain--;
        if (m_remain == 0) begin
          if (!m_freq) m_edges = m_edges + 32'd1;
          m_freq   = !m_freq;
          m_remain = jit(hpe);
          adv_lfsr();
        end
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_mode   = 2;
          m_remain = jit(hpe);
        end
      end else begin
        m_mode = 1;
        m_left = 100;
      end
      if (chg) begin
        m_mode = 1;
        m_left = 100;
      end
    end
    m_sc_p = m_sc_r; m_sc_r = scale;
    m_fl_p = m_fl_r; m_fl_r = filter;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("freq", sensorFreq, m_freq);
    chk("settling", settling, (m_mode == 1));
    chk("edge_cnt", edge_cnt, m_edges);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_freq", sensorFreq, 1'b0);
    chk("rst_settling", settling, 1'b0);
    chk("rst_edges", edge_cnt, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_settle(input logic lvl, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (settling === lvl) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    ok = (settling === lvl);
  endtask

  // Steps until sensorFreq leaves its current level; n = steps taken, -1 on timeout.
  task automatic count_toggle(input int max, output int n);
    logic lv;
    lv = sensorFreq;
    n  = 0;
    while (n < max) begin
      step();
      n++;
      if (sensorFreq !== lv) return;
    end
    n = -1;
  endtask

  task automatic check_hp(input string nm, input int n, input int hp);
`ifdef COLOR_EMU_JITTER_EN
    chk(nm, (n >= hp - 1) && (n <= hp + 1), 1'b1);
`else
    chk(nm, n, hp);
`endif
  endtask

  task automatic measure(input int hp, input string nm);
    bit ok;
    int n;
    wait_settle(1'b1, 10, ok);
    chk({nm, "_settle_on"}, ok, 1'b1);
    wait_settle(1'b0, 150, ok);
    chk({nm, "_settle_off"}, ok, 1'b1);
    count_toggle(4 * hp + 10, n);
    chk({nm, "_first_toggle"}, n > 0, 1'b1);
    count_toggle(4 * hp + 10, n);
    check_hp({nm, "_half_a"}, n, hp);
    count_toggle(4 * hp + 10, n);
    check_hp({nm, "_half_b"}, n, hp);
  endtask

  // Leaves the bench two cycles after a rising edge of sensorFreq.
  task automatic align_high();
    int n;
    if (sensorFreq !== 1'b1) begin
      count_toggle(2000, n);
      chk("align_rise", n > 0, 1'b1);
    end
    step();
    step();
  endtask

  initial begin
    int          n, len;
    logic        lv;
    logic [31:0] e0;

    tbl[0] = '{2'b11, 2'b00, 16'd10, 16'd4, 16'd8, 16'd3, 10};
    tbl[1] = '{2'b10, 2'b01, 16'd10, 16'd4, 16'd8, 16'd3, 20};
    tbl[2] = '{2'b01, 2'b01, 16'd10, 16'd4, 16'd8, 16'd3, 200};
    tbl[3] = '{2'b11, 2'b11, 16'd10, 16'd4, 16'd8, 16'd3, 8};
    tbl[4] = '{2'b11, 2'b10, 16'd10, 16'd4, 16'd8, 16'd3, 3};
    tbl[5] = '{2'b10, 2'b11, 16'd10, 16'd4, 16'd7, 16'd3, 35};

    // Reset with arbitrary inputs, then release into red at 100%.
    scale = 2'($urandom_range(0, 3)); filter = 2'($urandom_range(0, 3));
    red_hp = 16'($urandom); blue_hp = 16'($urandom); green_hp = 16'($urandom); clear_hp = 16'($urandom);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("t1_rst_freq", sensorFreq, 1'b0);
    chk("t1_rst_settling", settling, 1'b0);
    chk("t1_rst_edges", edge_cnt, 32'd0);
    scale = 2'b11; filter = 2'b00; red_hp = 16'd10; blue_hp = 16'd4; green_hp = 16'd8; clear_hp = 16'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t1_settling_hi", settling, 1'b1);
    end
    step();
    chk("t1_settling_lo", settling, 1'b0);
    repeat (99) step();
`ifndef COLOR_EMU_JITTER_EN
    chk("t2_edges_after_100", edge_cnt, 32'd5);
`endif

    // Table of steady configurations.
    for (int i = 0; i < 6; i++) begin
      scale = tbl[i].sc; filter = tbl[i].fl;
      red_hp = tbl[i].r; blue_hp = tbl[i].b; green_hp = tbl[i].g; clear_hp = tbl[i].c;
      if (i == 0) do_reset();
      measure(tbl[i].hp, $sformatf("tbl%0d", i));
    end

    // Filter switch mid half-period: level frozen through settle, then clear's period.
    scale = 2'b11; filter = 2'b11; green_hp = 16'd8; clear_hp = 16'd3;
    measure(8, "t4_green");
    step();
    step();
    lv = m_freq;
    filter = 2'b10;
    for (int i = 0; i < 102; i++) begin
      step();
      chk("t4_frozen", sensorFreq, lv);
    end
    count_toggle(50, n);
    chk("t4_first_toggle", n > 0, 1'b1);
    count_toggle(50, n);
    check_hp("t4_clear_half_a", n, 3);
    count_toggle(50, n);
    check_hp("t4_clear_half_b", n, 3);

    // Power-down and zero half-period.
    scale = 2'b11; filter = 2'b00; red_hp = 16'd10;
    measure(10, "t5_pre");
    align_high();
    e0 = m_edges;
    scale = 2'b00;
    step();
    step();
    chk("t5_pd_freq", sensorFreq, 1'b0);
    chk("t5_pd_settling", settling, 1'b0);
    repeat (40) step();
    chk("t5_pd_edges", edge_cnt, e0);
    scale = 2'b11;
    measure(10, "t5_resume");
    align_high();
    e0 = m_edges;
    red_hp = 16'd0;
    step();
    chk("t5_zero_freq", sensorFreq, 1'b0);
    repeat (40) step();
    chk("t5_zero_edges", edge_cnt, e0);
    red_hp = 16'd10;

`ifdef COLOR_EMU_JITTER_EN
    red_hp = 16'd100; scale = 2'b11; filter = 2'b00;
    do_reset();
    measure(100, "t6_jitter");
    for (int i = 0; i < 8; i++) begin
      count_toggle(400, n);
      check_hp("t6_half", n, 100);
    end
`endif

    // Randomized traffic, including mid-half-period half-period edits and one reset mid-run.
    for (int seg = 0; seg < 40; seg++) begin
      scale    = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      filter   = 2'($urandom_range(0, 3));
      red_hp   = 16'($urandom_range(0, 12));
      blue_hp  = 16'($urandom_range(0, 12));
      green_hp = 16'($urandom_range(0, 12));
      clear_hp = 16'($urandom_range(0, 12));
      if (seg == 20) do_reset();
      len = $urandom_range(30, 400);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 49) == 0) begin
          case ($urandom_range(0, 3))
            0:       red_hp   = 16'($urandom_range(0, 12));
            1:       blue_hp  = 16'($urandom_range(0, 12));
            2:       green_hp = 16'($urandom_range(0, 12));
            default: clear_hp = 16'($urandom_range(0, 12));
          endcase
        end
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
